// File: rtl/hilo_muldiv.sv
// Iterative one-bit-per-cycle multiply/divide unit owning the HI/LO result registers.
// Signed operands are reduced to magnitudes at issue and the result signs are restored in FIX.
module hilo_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             cancel,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] datain,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic [CW-1:0]    count;
   logic             is_div;
   logic             quo_neg;
   logic             rem_neg;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;

   logic             issue;
   logic             last_iter;
   logic             sign_a;
   logic             sign_b;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic             div_ok;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0] fix_hi;
   logic [WIDTH-1:0] fix_lo;

   assign issue     = (state == IDLE) && start && !cancel;
   assign last_iter = (count == CW'(WIDTH - 1));

   // op[0]=0 selects the signed variants; magnitudes are what the iteration loop sees
   assign sign_a = ~op[0] & opA[WIDTH-1];
   assign sign_b = ~op[0] & opB[WIDTH-1];
   assign abs_a  = sign_a ? -opA : opA;
   assign abs_b  = sign_b ? -opB : opB;

   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, operand};
   assign div_ok    = ~div_diff[WIDTH];

   // A zero divisor leaves quo_neg clear, so the all-ones quotient is never negated
   always_comb begin
      product = {acc_hi, acc_lo};
      if (quo_neg) begin
         product = -product;
      end
      fix_hi = product[2*WIDTH-1:WIDTH];
      fix_lo = product[WIDTH-1:0];
      if (is_div) begin
         fix_lo = quo_neg ? -acc_lo : acc_lo;
         fix_hi = rem_neg ? -acc_hi : acc_hi;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (issue) begin
               next_state = CALC;
            end
         end
         CALC: begin
            if (cancel) begin
               next_state = IDLE;
            end else if (last_iter) begin
               next_state = FIX;
            end
         end
         FIX: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_comb begin
      busy = (state == CALC) || (state == FIX);
   end

   // MUL keeps {upper partial product, remaining multiplier} in acc_hi:acc_lo;
   // DIV keeps {partial remainder, dividend shifting into quotient} in the same pair
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count   <= '0;
         is_div  <= 1'b0;
         quo_neg <= 1'b0;
         rem_neg <= 1'b0;
         operand <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (issue) begin
                  count   <= '0;
                  is_div  <= op[1];
                  acc_hi  <= '0;
                  if (op[1]) begin
                     quo_neg <= (sign_a ^ sign_b) && (opB != '0);
                     rem_neg <= sign_a;
                     acc_lo  <= abs_a;
                     operand <= abs_b;
                  end else begin
                     quo_neg <= sign_a ^ sign_b;
                     rem_neg <= 1'b0;
                     acc_lo  <= abs_b;
                     operand <= abs_a;
                  end
               end else if (!start) begin
                  if (mthi) begin
                     hi <= datain;
                  end
                  if (mtlo) begin
                     lo <= datain;
                  end
               end
            end
            CALC: begin
               if (!cancel) begin
                  count <= count + 1'b1;
                  if (is_div) begin
                     acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                  end else begin
                     acc_hi <= mul_sum[WIDTH:1];
                     acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                  end
               end
            end
            FIX: begin
               if (!cancel) begin
                  hi <= fix_hi;
                  lo <= fix_lo;
               end
            end
            default: begin
               count <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         done <= 1'b0;
      end else begin
         done <= (state == FIX) && !cancel;
      end
   end

endmodule
